// File: rtl/mem_seq_pkg.sv
// Purpose : shared types and constants for the 8x8 memory-bus initiator.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        RST,
        INIT_WS,
        INIT_WI,
        INIT_RI,
        INIT_RS,
        CLEAR,
        IDLE,
        ACCESS
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int MEM_WORDS = 8;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 8;
    localparam int HOLD_W    = 4;

    localparam logic [ADDR_W-1:0] INIT_ADDR = 3'b001;
    localparam logic [DATA_W-1:0] INIT_DATA = 8'h55;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    // Reload value for the hold timer: an access lasting N clocks counts N-1..0.
    function automatic logic [HOLD_W-1:0] hold_load(input int hold);
        return HOLD_W'(hold - 1);
    endfunction

endpackage

// File: rtl/mem_seq_initiator_hold_timer.sv
// Purpose : loadable 4-bit down-counter pacing how long an access stays on the memory pins.
// Latency : done reflects the registered count; a load takes effect on the next edge.
// Backpr. : none; load always wins over counting.
// Ports   : clk, rst (async, active-high), load + load_val (restart count), done (count == 0).
module hold_timer
    import mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    output logic              done
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_seq_initiator.sv
// Purpose : drives the 8x8 memory pins: power-up walk, clear of all words, then timed single-word accesses.
// Latency : request handshake to IDLE (and read response) is HOLD_CYCLES+1 clocks.
// Backpr. : o_reqReady only in IDLE; a held request waits there, never dropped or repeated.
// Ports   : i_clock/i_reset (async, active-high); request port i_req*/o_reqReady;
//           response o_rspValid/o_rspData; o_initDone; memory pins o_select/o_operation/o_addr/o_data, i_memData.
module mem_seq_initiator
    import mem_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_reqValid,
    output logic              o_reqReady,
    input  logic              i_reqWrite,
    input  logic [ADDR_W-1:0] i_reqAddr,
    input  logic [DATA_W-1:0] i_reqData,
    output logic              o_rspValid,
    output logic [DATA_W-1:0] o_rspData,
    output logic              o_initDone,
    output logic              o_select,
    output logic              o_operation,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_memData
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = hold_load(HOLD_CYCLES);

    state_t            state_q,     state_d;
    logic              sel_q,       sel_d;
    logic              op_q,        op_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              ready_q,     ready_d;
    logic              init_done_q, init_done_d;
    logic              rsp_vld_q,   rsp_vld_d;
    logic [DATA_W-1:0] rsp_dat_q,   rsp_dat_d;
    logic              req_write_q, req_write_d;
    logic              tmr_load;
    logic              tmr_done;

    hold_timer u_hold_timer (
        .clk      (i_clock),
        .rst      (i_reset),
        .load     (tmr_load),
        .load_val (HOLD_LOAD),
        .done     (tmr_done)
    );

    // Every output is a flop, so each branch computes the pin values for the
    // state being entered; the pins then match state_q after the edge.
    always_comb begin
        state_d     = state_q;
        sel_d       = 1'b0;
        op_d        = OP_READ;
        addr_d      = addr_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        init_done_d = init_done_q;
        rsp_vld_d   = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        req_write_d = req_write_q;
        tmr_load    = 1'b0;

        unique case (state_q)
            RST: begin
                state_d = INIT_WS;
                sel_d   = 1'b1;
                op_d    = OP_WRITE;
                addr_d  = INIT_ADDR;
                data_d  = INIT_DATA;
            end
            INIT_WS: begin
                state_d = INIT_WI;
                op_d    = OP_WRITE;
            end
            INIT_WI: begin
                state_d = INIT_RI;
            end
            INIT_RI: begin
                state_d = INIT_RS;
                sel_d   = 1'b1;
            end
            INIT_RS: begin
                state_d  = CLEAR;
                sel_d    = 1'b1;
                op_d     = OP_WRITE;
                addr_d   = '0;
                data_d   = '0;
                tmr_load = 1'b1;
            end
            CLEAR: begin
                if (tmr_done) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                    end else begin
                        sel_d    = 1'b1;
                        op_d     = OP_WRITE;
                        addr_d   = addr_q + ADDR_W'(1);
                        tmr_load = 1'b1;
                    end
                end else begin
                    sel_d = 1'b1;
                    op_d  = OP_WRITE;
                end
            end
            IDLE: begin
                // ready_q is a flop, so accepting never loops back into o_reqReady.
                if (i_reqValid && ready_q) begin
                    state_d     = ACCESS;
                    req_write_d = i_reqWrite;
                    sel_d       = 1'b1;
                    op_d        = i_reqWrite;
                    addr_d      = i_reqAddr;
                    data_d      = (i_reqWrite == OP_WRITE) ? i_reqData : '0;
                    tmr_load    = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ACCESS: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    // Read data is sampled on the edge that ends the hold window.
                    if (req_write_q == OP_READ) begin
                        rsp_vld_d = 1'b1;
                        rsp_dat_d = i_memData;
                    end
                end else begin
                    sel_d = 1'b1;
                    op_d  = req_write_q;
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= RST;
            sel_q       <= 1'b0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_dat_q   <= '0;
            req_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_dat_q   <= rsp_dat_d;
            req_write_q <= req_write_d;
        end
    end

    assign o_reqReady  = ready_q;
    assign o_rspValid  = rsp_vld_q;
    assign o_rspData   = rsp_dat_q;
    assign o_initDone  = init_done_q;
    assign o_select    = sel_q;
    assign o_operation = op_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_mem_seq_initiator.sv
// Purpose : directed bench for mem_seq_initiator with a behavioural 8x8 memory and a response scoreboard.
// Latency : n/a.
// Backpr. : n/a.
module tb_mem_seq_initiator;

    localparam int H = 5;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main instance (HOLD_CYCLES = 5) ----------------
    logic       i_reset, i_reqValid, i_reqWrite;
    logic [2:0] i_reqAddr;
    logic [7:0] i_reqData;
    logic       o_reqReady, o_rspValid, o_initDone, o_select, o_operation;
    logic [7:0] o_rspData, o_data, i_memData;
    logic [2:0] o_addr;

    mem_seq_initiator #(.HOLD_CYCLES(H)) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_reqValid  (i_reqValid),
        .o_reqReady  (o_reqReady),
        .i_reqWrite  (i_reqWrite),
        .i_reqAddr   (i_reqAddr),
        .i_reqData   (i_reqData),
        .o_rspValid  (o_rspValid),
        .o_rspData   (o_rspData),
        .o_initDone  (o_initDone),
        .o_select    (o_select),
        .o_operation (o_operation),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .i_memData   (i_memData)
    );

    // Memory model: seeded with a non-zero pattern during reset so the clear is observable.
    logic [7:0] mem [8];
    always @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'hA5;
        end else if (o_select && o_operation) begin
            mem[o_addr] <= o_data;
        end
    end
    assign i_memData = mem[o_addr];

    // ---------------- second instance (HOLD_CYCLES = 1) ----------------
    logic       r1, v1, w1;
    logic [2:0] a1;
    logic [7:0] d1;
    logic       rdy1, rv1, done1, sel1, op1;
    logic [7:0] rd1, dt1, md1;
    logic [2:0] ad1;

    mem_seq_initiator #(.HOLD_CYCLES(1)) dut1 (
        .i_clock     (clk),
        .i_reset     (r1),
        .i_reqValid  (v1),
        .o_reqReady  (rdy1),
        .i_reqWrite  (w1),
        .i_reqAddr   (a1),
        .i_reqData   (d1),
        .o_rspValid  (rv1),
        .o_rspData   (rd1),
        .o_initDone  (done1),
        .o_select    (sel1),
        .o_operation (op1),
        .o_addr      (ad1),
        .o_data      (dt1),
        .i_memData   (md1)
    );

    logic [7:0] mem1 [8];
    always @(posedge clk) begin
        if (r1) begin
            for (int i = 0; i < 8; i++) mem1[i] <= 8'hA5;
        end else if (sel1 && op1) begin
            mem1[ad1] <= dt1;
        end
    end
    assign md1 = mem1[ad1];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected read data and the cycle on which it must appear.
    logic [7:0] exp_dat_q [$];
    int         exp_due_q [$];
    logic [7:0] mon_dat;
    int         mon_due;

    always @(negedge clk) begin
        if (o_rspValid === 1'b1) begin
            if (exp_dat_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response %02h at cycle %0d, required none", o_rspData, cyc);
            end else begin
                mon_dat = exp_dat_q.pop_front();
                mon_due = exp_due_q.pop_front();
                check("rsp_data", 32'(o_rspData), 32'(mon_dat));
                check("rsp_cycle", 32'(cyc), 32'(mon_due));
            end
        end
    end

    logic sel_log [0:4095];
    always @(negedge clk) if (cyc < 4096) sel_log[cyc] <= o_select;

    int rel_cyc;

    // Releases reset just after an edge and checks every pin for edges 1..5+8H.
    task automatic reset_walk(input string tag);
        logic [14:0] e;
        @(posedge clk); #1;
        i_reset = 1'b0;
        rel_cyc = cyc;
        for (int k = 1; k <= 5 + 8 * H; k++) begin
            @(posedge clk); #1;
            case (k)
                1:       e = {1'b1, 1'b1, 3'd1, 8'h55, 1'b0, 1'b0};
                2:       e = {1'b0, 1'b1, 3'd1, 8'h55, 1'b0, 1'b0};
                3:       e = {1'b0, 1'b0, 3'd1, 8'h55, 1'b0, 1'b0};
                4:       e = {1'b1, 1'b0, 3'd1, 8'h55, 1'b0, 1'b0};
                default: begin
                    if (k == 5 + 8 * H) e = {1'b0, 1'b0, 3'd7, 8'h00, 1'b1, 1'b1};
                    else                e = {1'b1, 1'b1, 3'((k - 5) / H), 8'h00, 1'b0, 1'b0};
                end
            endcase
            check($sformatf("%s_edge%0d", tag, k),
                  32'({o_select, o_operation, o_addr, o_data, o_reqReady, o_initDone}), 32'(e));
        end
    endtask

    // Presents one request (d is the expected read data on reads) and returns its capture cycle.
    task automatic issue(input bit wr, input logic [2:0] a, input logic [7:0] d,
                         input bit push, input bit keep, output int cap);
        int n;
        n = 0;
        i_reqWrite = wr;
        i_reqAddr  = a;
        i_reqData  = d;
        i_reqValid = 1'b1;
        while (o_reqReady !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_wait_bound", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        cap = cyc;
        if (push) begin
            exp_dat_q.push_back(d);
            exp_due_q.push_back(cap + H);
        end
        check($sformatf("accept_pins_a%0d", a),
              32'({o_reqReady, o_select, o_operation, o_addr, o_data}),
              32'({1'b0, 1'b1, wr, a, (wr ? d : 8'h00)}));
        if (!keep) i_reqValid = 1'b0;
    endtask

    logic [7:0] wvals [5];
    int         cap, cap_a, cap_b, rises, n, t0, k1;

    initial begin
        wvals[0] = 8'h65; wvals[1] = 8'h6C; wvals[2] = 8'h69; wvals[3] = 8'h61; wvals[4] = 8'h73;
        i_reset = 1'b1; i_reqValid = 1'b0; i_reqWrite = 1'b0; i_reqAddr = '0; i_reqData = '0;
        r1 = 1'b1; v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;

        #23;
        check("reset_outputs",
              32'({o_select, o_operation, o_addr, o_data, o_reqReady, o_initDone, o_rspValid, o_rspData}), 32'd0);

        // Read of never-written address 7 held valid through the whole init sequence.
        i_reqValid = 1'b1; i_reqWrite = 1'b0; i_reqAddr = 3'd7; i_reqData = 8'h00;
        reset_walk("walk1");
        issue(1'b0, 3'd7, 8'h00, 1'b1, 1'b0, cap);
        check("first_accept_edge", 32'(cap - rel_cyc), 32'(6 + 8 * H));

        for (int i = 0; i < 5; i++) issue(1'b1, 3'(i), wvals[i], 1'b0, 1'b0, cap);
        for (int i = 0; i < 5; i++) issue(1'b0, 3'(i), wvals[i], 1'b1, 1'b0, cap);

        issue(1'b1, 3'd6, 8'h11, 1'b0, 1'b0, cap);
        repeat (8) @(posedge clk);
        #1;
        check("rsp_data_held", 32'(o_rspData), 32'h73);

        // Back-to-back: valid never drops between the two requests.
        issue(1'b1, 3'd5, 8'h3C, 1'b0, 1'b1, cap_a);
        issue(1'b0, 3'd5, 8'h3C, 1'b1, 1'b0, cap_b);
        check("b2b_spacing", 32'(cap_b - cap_a), 32'(H + 1));
        repeat (12) @(posedge clk);
        #1;
        check("b2b_sel_before_gap", 32'(sel_log[cap_a + H - 1]), 32'd1);
        check("b2b_sel_gap", 32'(sel_log[cap_a + H]), 32'd0);
        check("b2b_sel_second", 32'(sel_log[cap_b]), 32'd1);
        rises = 0;
        for (int c = cap_b + 1; c < cap_b + 12; c++) if (sel_log[c] && !sel_log[c - 1]) rises++;
        check("b2b_no_duplicate", 32'(rises), 32'd0);

        // Reset while a read is in flight: no response may ever appear for it.
        issue(1'b0, 3'd2, 8'h69, 1'b0, 1'b0, cap);
        @(posedge clk); #3;
        i_reset = 1'b1;
        #1;
        check("async_reset_outputs",
              32'({o_select, o_operation, o_addr, o_data, o_reqReady, o_initDone, o_rspValid, o_rspData}), 32'd0);
        @(posedge clk);
        reset_walk("walk2");
        issue(1'b0, 3'd2, 8'h00, 1'b1, 1'b0, cap);
        issue(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, cap);

        // HOLD_CYCLES = 1 instance.
        @(posedge clk); #1;
        r1 = 1'b0;
        k1 = 0;
        for (int k = 1; k <= 40 && k1 == 0; k++) begin
            @(posedge clk); #1;
            if (done1) k1 = k;
        end
        check("h1_init_done_edge", 32'(k1), 32'd13);
        v1 = 1'b1; w1 = 1'b1; a1 = 3'd3; d1 = 8'h5A;
        @(posedge clk); #1;
        v1 = 1'b0;
        n = 0;
        while (rdy1 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("h1_ready_bound", 32'(n < 20), 32'd1);
        v1 = 1'b1; w1 = 1'b0; a1 = 3'd3; d1 = 8'h00;
        t0 = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) v1 = 1'b0;
        end while (rv1 !== 1'b1 && n < 20);
        check("h1_read_latency", 32'(cyc - t0), 32'd2);
        check("h1_read_data", 32'(rd1), 32'h5A);

        n = 0;
        while (exp_dat_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("scoreboard_empty", 32'(exp_dat_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_seq_initiator.md
# mem_seq_initiator

Bus-side initiator for the 8x8 memory driver. It owns the memory's `select` / `operation` / `addr` / `data` pins. After reset it runs the mandatory power-up state walk, then clears all eight words to zero. It then turns single-word read/write requests, arriving on a valid/ready port, into timed memory cycles and returns read data on a one-cycle response strobe. It sits between system logic and the memory driver, replacing hand-driven stimulus.

## Interface
Parameters:
- `HOLD_CYCLES`, 5: clocks each access (clear, read, write) is held on the memory pins; legal range 1..15.

Ports:
- `i_clock`, in, 1: sole clock; all state updates on the rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_reqValid`, in, 1: request present.
- `o_reqReady`, out, 1: block can accept a request this cycle.
- `i_reqWrite`, in, 1: 1 = write, 0 = read.
- `i_reqAddr`, in, 3: word address.
- `i_reqData`, in, 8: write data; ignored on reads.
- `o_rspValid`, out, 1: one-cycle strobe, read data valid.
- `o_rspData`, out, 8: last read word; held until the next read completes.
- `o_initDone`, out, 1: power-up walk and clear have completed.
- `o_select`, out, 1: memory chip select.
- `o_operation`, out, 1: memory op, 1 = write, 0 = read.
- `o_addr`, out, 3: memory address.
- `o_data`, out, 8: memory write data.
- `i_memData`, in, 8: memory read data.

## Operation
- All outputs are registered. Every output resets to 0.
- States: `RST`, `INIT_WS`, `INIT_WI`, `INIT_RI`, `INIT_RS`, `CLEAR`, `IDLE`, `ACCESS`.
- `RST`: all memory pins are 0. Moves to `INIT_WS` on the first edge after `i_reset` falls.
- Power-up walk, one clock per state, with `o_addr` = 1 and `o_data` = 0x55 throughout:
  - `INIT_WS`: `op` = 1, `sel` = 1.
  - `INIT_WI`: `op` = 1, `sel` = 0.
  - `INIT_RI`: `op` = 0, `sel` = 0.
  - `INIT_RS`: `op` = 0, `sel` = 1.
- `CLEAR`:
  - Drives `sel` = 1, `op` = 1, `data` = 0.
  - Presents addresses 0..7 in order, each for `HOLD_CYCLES` clocks, then enters `IDLE`.
- `IDLE`:
  - Drives `sel` = 0, `op` = 0; `o_addr` and `o_data` keep their last values.
  - `o_reqReady` = 1 and `o_initDone` = 1.
  - On `i_reqValid` && `o_reqReady`, the block latches write/addr/data and moves to `ACCESS`.
- `ACCESS`:
  - Drives `sel` = 1, `op` = latched write bit, `addr`, `data` (`data` = 0 on reads) for `HOLD_CYCLES` clocks, then returns to `IDLE`.
  - Read: on the transition edge, `o_rspData` <= `i_memData` and `o_rspValid` = 1 for exactly one cycle.
  - Write: no response.
- `o_reqReady` is 0 in every state except `IDLE`. A request that stays valid while not ready is neither dropped nor duplicated; it is accepted on its first `IDLE` cycle.
- `o_initDone` rises on entry to `IDLE` and stays high until reset.
- The hold counter width is 4 bits. It counts `HOLD_CYCLES`-1 down to 0; the state advances when the count is 0.
- Reset asserted mid-operation, in any state:
  - All outputs go to 0 immediately (asynchronous).
  - Any latched request is discarded with no response.
  - The full walk and clear run again after release.

## Timing
Reset release is edge 0.
- Edges 1-4: the four `INIT_*` states.
- Edges 5 .. 4+8·`HOLD_CYCLES`: `CLEAR`. With the default of 5 this is edges 5-44.
- Edge 5+8·`HOLD_CYCLES` (edge 45 by default): `IDLE`, with `o_initDone` = 1 and `o_reqReady` = 1.

For a request accepted at edge N:
- Memory pins show the access from edge N+1 through edge N+`HOLD_CYCLES`.
- At edge N+`HOLD_CYCLES`+1: `IDLE`, `o_reqReady` = 1; on reads, `o_rspValid` = 1 and `o_rspData` is valid.
- Minimum request spacing is `HOLD_CYCLES`+1 clocks.

No combinational path exists from `i_reqValid` to `o_reqReady`.

## Structure
- Package `mem_seq_pkg` holds:
  - the state enum;
  - `OP_READ` = 0 and `OP_WRITE` = 1;
  - `MEM_WORDS` = 8 and `ADDR_W` = 3;
  - init constants `INIT_ADDR` = 3'b001 and `INIT_DATA` = 8'h55.
- Sub-module `hold_timer`:
  - loadable 4-bit down-counter with a `done` flag;
  - used by both `CLEAR` and `ACCESS`.

## Test plan
- **Reset, then idle request valid:** pins follow the four-step walk on edges 1-4, then eight 5-clock clears at addresses 0..7. `o_initDone` = 1 at edge 45. No request is accepted before edge 45.
- **Write/read-back:** writes 0x65, 0x6C, 0x69, 0x61, 0x73 to addresses 0-4, then reads addresses 0-4. `o_rspData` returns the same five values, with exactly one `o_rspValid` per read, each 6 clocks after accept.
- **Read of a never-written address after clear:** a read of address 7 returns 0x00.
- **Back-to-back handshake:** `i_reqValid` is held high with two queued requests. Accepts occur exactly 6 clocks apart, `sel` drops for 1 clock between them, and neither request is lost nor duplicated.
- **Reset during `ACCESS`:** a read is in flight. Outputs go to 0 asynchronously, no `o_rspValid` appears, and the walk and clear repeat after release.
- **`HOLD_CYCLES` = 1:** `o_initDone` rises at edge 13, and read latency is 2 clocks.
